// File: rtl/axil_cmd_master_if.sv
// axil_cmd_master_if: AXI4-Lite master/slave signal bundle
interface axil_cmd_master_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  logic                  awvalid;
  logic                  awready;
  logic [ADDR_W-1:0]     awaddr;
  logic [2:0]            awprot;
  logic                  wvalid;
  logic                  wready;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   wstrb;
  logic                  bvalid;
  logic                  bready;
  logic [1:0]            bresp;
  logic                  arvalid;
  logic                  arready;
  logic [ADDR_W-1:0]     araddr;
  logic [2:0]            arprot;
  logic                  rvalid;
  logic                  rready;
  logic [DATA_W-1:0]     rdata;
  logic [1:0]            rresp;
  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready, arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready, arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axil_cmd_master.sv
// axil_cmd_master: queued command port to AXI4-Lite master, one transaction in flight, with response timeout
module axil_cmd_master #(
  parameter int         ADDR_W    = 4,
  parameter int         DATA_W    = 32,
  parameter int         CMD_DEPTH = 4,
  parameter int         TIMEOUT   = 1023,
  parameter logic [2:0] PROT      = 3'b000
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_valid,
  input  logic                i_write,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic [DATA_W-1:0]   i_data,
  input  logic [DATA_W/8-1:0] i_strb,
  output logic                o_cmd_busy,
  output logic                o_rsp_stb,
  output logic [DATA_W-1:0]   o_rsp_word,
  output logic [1:0]          o_rsp_err,
  output logic                o_rsp_timeout,
  axil_cmd_master_if.master   m_axi
);
  localparam int STRB_W = DATA_W / 8;
  localparam int PW = $clog2(CMD_DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = 1 + ADDR_W + DATA_W + STRB_W;
  localparam int TW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {IDLE, WR_ADDR_DATA, WAIT_B, RD_ADDR, WAIT_R, DRAIN} state_t;

  logic [EW-1:0] mem [CMD_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [EW-1:0] head;
  logic push, pop, rsp_hs;

  state_t state, state_n;
  logic aw_v, w_v, ar_v, b_r, r_r;
  logic aw_n, w_n, ar_n, b_n, r_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [DATA_W-1:0] data_q, data_n;
  logic [STRB_W-1:0] strb_q, strb_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic stb_n, to_n;
  logic [DATA_W-1:0] word_n;
  logic [1:0] err_n;

  assign push = i_valid && !o_cmd_busy;
  assign o_cmd_busy = count == CW'(CMD_DEPTH);
  assign head = mem[rd_ptr];
  assign rsp_hs = (b_r && m_axi.bvalid) || (r_r && m_axi.rvalid);

  always_ff @(posedge i_clk)
    if (push) mem[wr_ptr] <= {i_write, i_addr, i_data, i_strb};

  always_ff @(posedge i_clk)
    if (i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push);
      rd_ptr <= rd_ptr + PW'(pop);
      count  <= count + CW'(push) - CW'(pop);
    end

  // Every registered output has a *_n twin so the next-state process owns all decisions.
  always_comb begin
    state_n = state;
    aw_n    = aw_v;
    w_n     = w_v;
    ar_n    = ar_v;
    b_n     = b_r;
    r_n     = r_r;
    addr_n  = addr_q;
    data_n  = data_q;
    strb_n  = strb_q;
    tcnt_n  = &tcnt ? tcnt : tcnt + 1'b1;
    stb_n   = 1'b0;
    to_n    = 1'b0;
    word_n  = o_rsp_word;
    err_n   = o_rsp_err;
    pop     = 1'b0;
    case (state)
      IDLE: if (count != '0) begin
        pop = 1'b1;
        {addr_n, data_n, strb_n} = head[EW-2:0];
        aw_n = head[EW-1];
        w_n  = head[EW-1];
        ar_n = !head[EW-1];
        state_n = head[EW-1] ? WR_ADDR_DATA : RD_ADDR;
      end
      WR_ADDR_DATA: begin
        aw_n = aw_v && !m_axi.awready;
        w_n  = w_v && !m_axi.wready;
        if (!aw_n && !w_n) begin
          b_n = 1'b1;
          tcnt_n = '0;
          state_n = WAIT_B;
        end
      end
      RD_ADDR: if (m_axi.arready) begin
        ar_n = 1'b0;
        r_n = 1'b1;
        tcnt_n = '0;
        state_n = WAIT_R;
      end
      WAIT_B, WAIT_R: if (rsp_hs) begin
        b_n = 1'b0;
        r_n = 1'b0;
        stb_n = 1'b1;
        err_n = state == WAIT_B ? m_axi.bresp : m_axi.rresp;
        word_n = state == WAIT_R ? m_axi.rdata : '0;
        state_n = IDLE;
      end else if (TIMEOUT != 0 && tcnt == TLIM) begin
        // Ready stays high so DRAIN can swallow the late response.
        stb_n = 1'b1;
        to_n = 1'b1;
        err_n = 2'b11;
        word_n = '0;
        state_n = DRAIN;
      end
      DRAIN: if (rsp_hs) begin
        b_n = 1'b0;
        r_n = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_clk)
    if (i_reset) begin
      state         <= IDLE;
      aw_v          <= 1'b0;
      w_v           <= 1'b0;
      ar_v          <= 1'b0;
      b_r           <= 1'b0;
      r_r           <= 1'b0;
      addr_q        <= '0;
      data_q        <= '0;
      strb_q        <= '0;
      tcnt          <= '0;
      o_rsp_stb     <= 1'b0;
      o_rsp_word    <= '0;
      o_rsp_err     <= '0;
      o_rsp_timeout <= 1'b0;
    end else begin
      state         <= state_n;
      aw_v          <= aw_n;
      w_v           <= w_n;
      ar_v          <= ar_n;
      b_r           <= b_n;
      r_r           <= r_n;
      addr_q        <= addr_n;
      data_q        <= data_n;
      strb_q        <= strb_n;
      tcnt          <= tcnt_n;
      o_rsp_stb     <= stb_n;
      o_rsp_word    <= word_n;
      o_rsp_err     <= err_n;
      o_rsp_timeout <= to_n;
    end

  assign m_axi.awvalid = aw_v;
  assign m_axi.awaddr  = addr_q;
  assign m_axi.awprot  = PROT;
  assign m_axi.wvalid  = w_v;
  assign m_axi.wdata   = data_q;
  assign m_axi.wstrb   = strb_q;
  assign m_axi.bready  = b_r;
  assign m_axi.arvalid = ar_v;
  assign m_axi.araddr  = addr_q;
  assign m_axi.arprot  = PROT;
  assign m_axi.rready  = r_r;
endmodule

// File: tb/tb_axil_cmd_master.sv
// tb_axil_cmd_master: directed and random checks of the command bridge against a memory-level model
module tb_axil_cmd_master;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;
  localparam int DEPTH  = 4;
  localparam int TMO    = 8;

  logic i_clk = 1'b0;
  logic i_reset = 1'b1;
  logic i_valid = 1'b0;
  logic i_write = 1'b0;
  logic [ADDR_W-1:0] i_addr = '0;
  logic [DATA_W-1:0] i_data = '0;
  logic [STRB_W-1:0] i_strb = '0;
  logic o_cmd_busy, o_rsp_stb, o_rsp_timeout;
  logic [DATA_W-1:0] o_rsp_word;
  logic [1:0] o_rsp_err;

  axil_cmd_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  axil_cmd_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CMD_DEPTH(DEPTH), .TIMEOUT(TMO), .PROT(3'b010)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .i_write(i_write), .i_addr(i_addr),
    .i_data(i_data), .i_strb(i_strb), .o_cmd_busy(o_cmd_busy), .o_rsp_stb(o_rsp_stb),
    .o_rsp_word(o_rsp_word), .o_rsp_err(o_rsp_err), .o_rsp_timeout(o_rsp_timeout), .m_axi(bus)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0] word;
    logic [1:0]  err;
    logic        to;
  } rsp_t;
  rsp_t exp_q[$];

  logic [31:0] smem [16];
  logic [31:0] mmem [16];
  logic [1:0]  err_map [16];
  int aw_dly = 0, w_dly = 0, ar_dly = 0, rsp_dly = 0;

  // Slave: decides readies/valids on the falling edge, so a handshake flagged here lands on the next rising edge.
  int aw_wait, w_wait, ar_wait, rsp_wait;
  logic hs_aw, hs_w, hs_ar, hs_b, hs_r;
  logic aw_got, w_got, ar_got, applied;
  logic pv_aw, pv_w, pv_ar;
  logic [ADDR_W-1:0] aw_a, ar_a, pa_aw, pa_ar;
  logic [31:0] w_d, pd_w;
  logic [3:0] w_s, ps_w;

  always @(negedge i_clk) begin
    if (i_reset) begin
      bus.awready = 1'b0; bus.wready = 1'b0; bus.arready = 1'b0;
      bus.bvalid = 1'b0; bus.rvalid = 1'b0; bus.bresp = '0; bus.rresp = '0; bus.rdata = '0;
      {hs_aw, hs_w, hs_ar, hs_b, hs_r} = '0;
      {aw_got, w_got, ar_got, applied, pv_aw, pv_w, pv_ar} = '0;
      aw_wait = 0; w_wait = 0; ar_wait = 0; rsp_wait = 0;
    end else begin
      if (pv_aw && !hs_aw) begin chk("aw_held", bus.awvalid, 1); chk("aw_addr_stable", bus.awaddr, pa_aw); end
      if (pv_w && !hs_w) begin chk("w_held", bus.wvalid, 1); chk("w_data_stable", {bus.wstrb, bus.wdata}, {ps_w, pd_w}); end
      if (pv_ar && !hs_ar) begin chk("ar_held", bus.arvalid, 1); chk("ar_addr_stable", bus.araddr, pa_ar); end
      if (hs_aw) aw_got = 1'b1;
      if (hs_w) w_got = 1'b1;
      if (hs_ar) ar_got = 1'b1;
      if (hs_b) begin bus.bvalid = 1'b0; aw_got = 1'b0; w_got = 1'b0; applied = 1'b0; rsp_wait = 0; end
      if (hs_r) begin bus.rvalid = 1'b0; ar_got = 1'b0; rsp_wait = 0; end
      if (aw_got && w_got && !applied) begin
        applied = 1'b1;
        for (int b = 0; b < 4; b++) if (w_s[b]) smem[aw_a][8*b +: 8] = w_d[8*b +: 8];
      end
      if (aw_got && w_got && !bus.bvalid) begin
        if (rsp_wait >= rsp_dly) begin bus.bvalid = 1'b1; bus.bresp = err_map[aw_a]; end
        else rsp_wait++;
      end
      if (ar_got && !bus.rvalid) begin
        if (rsp_wait >= rsp_dly) begin bus.rvalid = 1'b1; bus.rdata = smem[ar_a]; bus.rresp = err_map[ar_a]; end
        else rsp_wait++;
      end
      bus.awready = bus.awvalid && aw_wait >= aw_dly;
      aw_wait = bus.awvalid ? aw_wait + 1 : 0;
      bus.wready = bus.wvalid && w_wait >= w_dly;
      w_wait = bus.wvalid ? w_wait + 1 : 0;
      bus.arready = bus.arvalid && ar_wait >= ar_dly;
      ar_wait = bus.arvalid ? ar_wait + 1 : 0;
      hs_aw = bus.awvalid && bus.awready;
      hs_w = bus.wvalid && bus.wready;
      hs_ar = bus.arvalid && bus.arready;
      hs_b = bus.bvalid && bus.bready;
      hs_r = bus.rvalid && bus.rready;
      if (hs_aw) aw_a = bus.awaddr;
      if (hs_w) begin w_d = bus.wdata; w_s = bus.wstrb; end
      if (hs_ar) ar_a = bus.araddr;
      pv_aw = bus.awvalid; pa_aw = bus.awaddr;
      pv_w = bus.wvalid; pd_w = bus.wdata; ps_w = bus.wstrb;
      pv_ar = bus.arvalid; pa_ar = bus.araddr;
    end
  end

  rsp_t got_e;
  always @(negedge i_clk)
    if (!i_reset && o_rsp_stb) begin
      chk("stb_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        got_e = exp_q.pop_front();
        chk("rsp_timeout", o_rsp_timeout, got_e.to);
        chk("rsp_err", o_rsp_err, got_e.err);
        if (!got_e.to) chk("rsp_word", o_rsp_word, got_e.word);
      end
    end

  // Called on a falling edge; the command is accepted on the following rising edge.
  task automatic send(input logic w, input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    rsp_t e;
    int n = 0;
    while (o_cmd_busy && n < 300) begin @(negedge i_clk); n++; end
    chk("send_busy_wait", o_cmd_busy, 0);
    i_valid = 1'b1; i_write = w; i_addr = a; i_data = d; i_strb = s;
    e.to = rsp_dly >= TMO;
    e.err = e.to ? 2'b11 : err_map[a];
    e.word = w ? 32'h0 : mmem[a];
    if (w) for (int b = 0; b < 4; b++) if (s[b]) mmem[a][8*b +: 8] = d[8*b +: 8];
    exp_q.push_back(e);
    @(negedge i_clk);
    i_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_q.size() != 0 || bus.bready || bus.rready) && n < 2000) begin @(negedge i_clk); n++; end
    chk(tag, exp_q.size(), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, k;
    for (int i = 0; i < 16; i++) begin
      smem[i] = $urandom;
      mmem[i] = smem[i];
      err_map[i] = 2'($urandom_range(0, 3));
    end
    repeat (3) @(negedge i_clk);
    chk("rst_busy", o_cmd_busy, 0);
    chk("rst_stb", o_rsp_stb, 0);
    chk("rst_valids", {bus.awvalid, bus.wvalid, bus.arvalid}, 0);
    chk("rst_readies", {bus.bready, bus.rready}, 0);
    chk("rst_rsp", {o_rsp_word, o_rsp_err, o_rsp_timeout}, 0);
    i_reset = 1'b0;
    @(negedge i_clk);

    // Simple write: AWVALID two cycles after acceptance, response one cycle after B.
    err_map[4] = 2'b00;
    send(1'b1, 4'h4, 32'hDEADBEEF, 4'hF);
    chk("t1_aw_n1", bus.awvalid, 0);
    @(negedge i_clk);
    chk("t1_aw_n2", bus.awvalid, 1);
    chk("t1_w_n2", bus.wvalid, 1);
    chk("t1_awaddr", bus.awaddr, 4'h4);
    chk("t1_wdata", bus.wdata, 32'hDEADBEEF);
    chk("t1_wstrb", bus.wstrb, 4'hF);
    chk("t1_awprot", bus.awprot, 3'b010);
    @(negedge i_clk);
    chk("t1_bready", bus.bready, 1);
    chk("t1_stb_early", o_rsp_stb, 0);
    @(negedge i_clk);
    chk("t1_stb", o_rsp_stb, 1);
    chk("t1_word", o_rsp_word, 0);
    chk("t1_err", o_rsp_err, 0);
    drain("t1_drain");

    // W accepted three cycles before AW.
    aw_dly = 3;
    send(1'b1, 4'hC, $urandom, 4'b0101);
    @(negedge i_clk);
    chk("t2_both_valid", {bus.awvalid, bus.wvalid}, 2'b11);
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      chk("t2_w_first", bus.wvalid, 0);
      chk("t2_aw_held", bus.awvalid, 1);
      chk("t2_no_bready", bus.bready, 0);
    end
    @(negedge i_clk);
    chk("t2_aw_done", bus.awvalid, 0);
    chk("t2_bready", bus.bready, 1);
    @(negedge i_clk);
    chk("t2_stb", o_rsp_stb, 1);
    aw_dly = 0;
    drain("t2_drain");

    // Read with SLVERR.
    smem[8] = 32'h12345678; mmem[8] = 32'h12345678; err_map[8] = 2'b10;
    send(1'b0, 4'h8, 32'h0, 4'h0);
    n = 0;
    while (!o_rsp_stb && n < 20) begin @(negedge i_clk); n++; end
    chk("t3_word", o_rsp_word, 32'h12345678);
    chk("t3_err", o_rsp_err, 2'b10);
    chk("t3_timeout", o_rsp_timeout, 0);
    @(negedge i_clk);
    chk("t3_one_pulse", o_rsp_stb, 0);
    drain("t3_drain");

    // Queue fill with ARREADY stuck low: 4 queued + 1 in flight.
    ar_dly = 1000;
    for (int i = 0; i < 4; i++) send(1'b0, 4'(i), 32'h0, 4'h0);
    chk("t4_not_busy_4", o_cmd_busy, 0);
    send(1'b0, 4'd4, 32'h0, 4'h0);
    chk("t4_busy_5", o_cmd_busy, 1);
    chk("t4_ar_stall", bus.arvalid, 1);
    ar_dly = 0;
    send(1'b0, 4'd5, 32'h0, 4'h0);
    drain("t4_drain");

    // Missing B: timeout after TMO waiting cycles, late B absorbed.
    rsp_dly = 20;
    send(1'b1, 4'h2, $urandom, 4'($urandom_range(0, 15)));
    n = 0;
    while (!bus.bready && n < 50) begin @(negedge i_clk); n++; end
    k = 0;
    while (!o_rsp_stb && k < 50) begin @(negedge i_clk); k++; end
    chk("t5_stb_delay", k, TMO);
    chk("t5_timeout", o_rsp_timeout, 1);
    chk("t5_err", o_rsp_err, 2'b11);
    drain("t5_drain");
    rsp_dly = TMO - 1;
    send(1'b0, 4'h2, 32'h0, 4'h0);
    drain("t5_edge_win");
    rsp_dly = TMO;
    send(1'b0, 4'h2, 32'h0, 4'h0);
    drain("t5_edge_lose");
    rsp_dly = 0;
    send(1'b1, 4'h3, $urandom, 4'hF);
    drain("t5_after");

    // Reset while waiting for R with two commands queued.
    rsp_dly = 6;
    send(1'b0, 4'h1, 32'h0, 4'h0);
    send(1'b0, 4'h5, 32'h0, 4'h0);
    send(1'b0, 4'h6, 32'h0, 4'h0);
    chk("t6_in_wait_r", bus.rready, 1);
    i_reset = 1'b1;
    @(negedge i_clk);
    chk("t6_valids", {bus.awvalid, bus.wvalid, bus.arvalid}, 0);
    chk("t6_readies", {bus.bready, bus.rready}, 0);
    chk("t6_busy", o_cmd_busy, 0);
    chk("t6_stb", o_rsp_stb, 0);
    chk("t6_rsp", {o_rsp_word, o_rsp_err, o_rsp_timeout}, 0);
    exp_q.delete();
    @(negedge i_clk);
    i_reset = 1'b0;
    rsp_dly = 0;
    @(negedge i_clk);
    chk("t6_queue_empty", {bus.arvalid, o_rsp_stb}, 0);
    send(1'b0, 4'h7, 32'h0, 4'h0);
    drain("t6_after");

    // Random traffic against the memory model.
    for (int b = 0; b < 4; b++) begin
      aw_dly = $urandom_range(0, 3);
      w_dly = $urandom_range(0, 3);
      ar_dly = $urandom_range(0, 3);
      rsp_dly = $urandom_range(0, 10);
      for (int i = 0; i < 12; i++) begin
        if ($urandom_range(0, 3) == 0) @(negedge i_clk);
        send(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)));
      end
      drain("rand_drain");
    end
    repeat (5) @(negedge i_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
